// File: rtl/onehot_decoder_stream_pkg.sv
//============================================================================
// Module : onehot_decoder_stream_pkg
// Brief  : Shared defaults and occupancy-state encodings for the decoder.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package onehot_decoder_stream_pkg;

    localparam int DEF_IN_W  = 3;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

`default_nettype wire

// File: rtl/onehot_decoder_stream_skid.sv
//============================================================================
// Module : skid_buffer
// Brief  : Two-entry valid/ready register pair (main + skid), strict FIFO.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module skid_buffer
    import onehot_decoder_stream_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    occ_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q;
    logic         in_fire, out_fire;

    assign in_fire     = in_valid_i & ready_q;
    assign out_fire    = (state_q != ST_EMPTY) & out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && !out_fire) begin
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (in_fire && out_fire) begin
                    main_d  = in_data_i;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Ready is registered from the next state so it drops the cycle skid fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

endmodule

`default_nettype wire

// File: rtl/onehot_decoder_stream.sv
//============================================================================
// Module : onehot_decoder_stream
// Brief  : Streaming binary-to-one-hot decoder with per-line hit counters.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module onehot_decoder_stream
    import onehot_decoder_stream_pkg::*;
#(
    parameter  int IN_W  = DEF_IN_W,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    input  logic [IN_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_clr
);

    logic [IN_W-1:0]  code_q;
    logic             out_fire;
    logic [CNT_W-1:0] cnt_all [OUT_W];

    skid_buffer #(.W(IN_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_code),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (code_q)
    );

    assign out_fire = out_valid & out_ready;

    // Decoded from the held code register only, and forced to zero when idle.
    always_comb begin
        out_onehot = '0;
        if (out_valid) begin
            out_onehot[code_q] = 1'b1;
        end
    end

    for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (out_fire && (code_q == IN_W'(i)) && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_all[i] = cnt_q;
    end

    assign cnt_val = cnt_all[cnt_sel];

endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder_stream.sv
//============================================================================
// Module : tb_onehot_decoder_stream
// Brief  : Self-checking bench: vector table plus scoreboard queue.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_onehot_decoder_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [2:0] cnt_sel;
    logic [3:0] cnt_val;
    logic       cnt_clr;

    onehot_decoder_stream #(.IN_W(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] sb [$];
    int         n_chk;
    int         n_fail;
    logic       prev_stall;
    logic [7:0] prev_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs are already driven; evaluate handshakes before the edge, then advance.
    task automatic cycle(input logic [7:0] exp_push);
        logic [7:0] exp;
        #1;
        if (prev_stall) chk("hold_stable", out_onehot, prev_word);
        if (!out_valid) chk("idle_zero", out_onehot, 8'h00);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h, expected no word", out_onehot);
            end else begin
                exp = sb.pop_front();
                chk("out_word", out_onehot, exp);
            end
        end
        if (in_valid && in_ready) sb.push_back(exp_push);
        prev_stall = out_valid && !out_ready;
        prev_word  = out_onehot;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        prev_stall = 1'b0;
        prev_word  = 8'h00;
        vecs[0] = '{3'd0, 8'h01};
        vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04};
        vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10};
        vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40};
        vecs[7] = '{3'd7, 8'h80};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b0;
        cnt_sel   = 3'd0;
        cnt_clr   = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_onehot", out_onehot, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt_val", cnt_val, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep: every code, continuous accept and drain
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = vecs[i].code;
            chk("sweep_in_ready", in_ready, 1'b1);
            if (i > 0) chk("sweep_no_bubble", out_valid, 1'b1);
            cycle(vecs[i].exp);
        end
        in_valid = 1'b0;
        cycle(8'h00);
        chk("sweep_drained", out_valid, 1'b0);

        // Simultaneous fire in BUSY, reverse order
        in_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            in_code = vecs[i].code;
            chk("busy_in_ready", in_ready, 1'b1);
            if (i < 7) chk("busy_no_bubble", out_valid, 1'b1);
            cycle(vecs[i].exp);
        end
        in_valid = 1'b0;
        cycle(8'h00);

        // Backpressure: 3 then 5 with downstream stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd3;
        cycle(8'h08);
        chk("bp_ready_after_1", in_ready, 1'b1);
        in_code = 3'd5;
        cycle(8'h20);
        chk("bp_ready_after_2", in_ready, 1'b0);
        chk("bp_head_word", out_onehot, 8'h08);
        in_code = 3'd1;
        cycle(8'h02);
        in_valid = 1'b0;
        cycle(8'h00);
        chk("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        cycle(8'h00);
        chk("bp_ready_back", in_ready, 1'b1);
        cycle(8'h00);
        chk("bp_drained", out_valid, 1'b0);

        // Counters: clear, small count, then saturate line 6
        cnt_clr = 1'b1;
        cycle(8'h00);
        cnt_clr  = 1'b0;
        in_valid = 1'b1;
        in_code  = 3'd2;
        for (int i = 0; i < 3; i++) cycle(8'h04);
        in_valid = 1'b0;
        cycle(8'h00);
        cnt_sel = 3'd2;
        #1;
        chk("cnt_line2", cnt_val, 4'd3);
        in_valid = 1'b1;
        in_code  = 3'd6;
        for (int i = 0; i < 20; i++) cycle(8'h40);
        in_valid = 1'b0;
        cycle(8'h00);
        cnt_sel = 3'd6;
        #1;
        chk("cnt_saturate", cnt_val, 4'd15);
        for (int s = 0; s < 8; s++) begin
            if (s != 6 && s != 2) begin
                cnt_sel = 3'(s);
                #1;
                chk("cnt_other_zero", cnt_val, 4'd0);
            end
        end

        // Mid-reset while FULL, asserted between edges
        cnt_sel   = 3'd6;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd4;
        cycle(8'h10);
        in_code = 3'd7;
        cycle(8'h80);
        chk("mr_full", in_ready, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_out_onehot", out_onehot, 8'h00);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_cnt_val", cnt_val, 4'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_post_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'd1;
        cycle(8'h02);
        in_valid = 1'b0;
        chk("mr_first_word", out_onehot, 8'h02);
        cycle(8'h00);
        chk("mr_empty", out_valid, 1'b0);

        // Clear wins over a same-cycle fire
        in_valid = 1'b1;
        in_code  = 3'd6;
        cycle(8'h40);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        cycle(8'h00);
        cnt_clr = 1'b0;
        cnt_sel = 3'd6;
        #1;
        chk("cnt_clr_wins", cnt_val, 4'd0);

        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
